// File: rtl/param_muldiv_alu.sv
// param_muldiv_alu
//   Single-cycle ALU (AND/OR/ADD/SUB/SLT/SLL/SRL/MFHI/MFLO) with a registered
//   result, plus a multi-cycle unsigned multiply/divide unit that writes Hi/Lo.
//   MULTU is a shift-add and DIVU a restoring divide. Each processes one bit
//   per cycle for WIDTH cycles.
// Ports
//   clk    : clock; all state changes on its rising edge
//   reset  : synchronous, active-high
//   dataA  : operand A (WIDTH bits)
//   dataB  : operand B (WIDTH bits); the low SHW bits are the shift amount
//   Signal : 6-bit function code
//   start  : launches MULTU/DIVU when the unit is idle
//   Output : registered result, one cycle after the inputs are sampled
//   busy   : multiply/divide in progress
//   done   : one-cycle pulse when Hi/Lo take a new result
module param_muldiv_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  input  logic             start,
  output logic [WIDTH-1:0] Output,
  output logic             busy,
  output logic             done
);

  typedef enum logic [5:0] {
    F_SLL   = 6'd0,
    F_SRL   = 6'd2,
    F_MFHI  = 6'd16,
    F_MFLO  = 6'd18,
    F_MULTU = 6'd25,
    F_DIVU  = 6'd27,
    F_ADD   = 6'd32,
    F_SUB   = 6'd34,
    F_AND   = 6'd36,
    F_OR    = 6'd37,
    F_SLT   = 6'd42
  } func_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 last_step;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_trial;
  logic [2*WIDTH-1:0]   step_w;

  // Single-cycle ALU. MULTU/DIVU and undefined codes return zero.
  always_comb begin
    out_d = '0;
    unique case (Signal)
      F_AND:   out_d = dataA & dataB;
      F_OR:    out_d = dataA | dataB;
      F_ADD:   out_d = dataA + dataB;
      F_SUB:   out_d = dataA - dataB;
      F_SLT:   out_d = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      F_SLL:   out_d = dataA << dataB[SHW-1:0];
      F_SRL:   out_d = dataA >> dataB[SHW-1:0];
      F_MFHI:  out_d = hi_q;
      F_MFLO:  out_d = lo_q;
      default: out_d = '0;
    endcase
  end

  // One iteration of the shared datapath. work_q holds {upper, lower}:
  //   MULTU: {partial product, remaining multiplier bits}, shifted right
  //   DIVU : {partial remainder, dividend bits/quotient}, shifted left
  // Division by zero needs no special case. Every trial subtract then
  // succeeds, so the quotient fills with ones and the remainder collects
  // the whole dividend.
  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
    div_trial = work_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    step_w    = '0;
    if (is_div_q) begin
      if (!div_trial[WIDTH]) begin
        step_w = {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
      end else begin
        step_w = {work_q[2*WIDTH-2:0], 1'b0};
      end
    end else begin
      step_w = {mul_sum, work_q[WIDTH-1:1]};
    end
  end

  assign accept    = (state_q == IDLE) && start &&
                     ((Signal == F_MULTU) || (Signal == F_DIVU));
  assign last_step = (cnt_q == SHW'(WIDTH - 1));

  // Multiply/divide controller.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opb_d    = opb_q;
    work_d   = work_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = RUN;
          cnt_d    = '0;
          is_div_d = (Signal == F_DIVU);
          opb_d    = dataB;
          work_d   = {{WIDTH{1'b0}}, dataA};
        end
      end
      RUN: begin
        work_d = step_w;
        cnt_d  = cnt_q + 1'b1;
        if (last_step) begin
          state_d = IDLE;
          hi_d    = step_w[2*WIDTH-1:WIDTH];
          lo_d    = step_w[WIDTH-1:0];
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opb_q    <= '0;
      work_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opb_q    <= opb_d;
      work_q   <= work_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      out_q    <= out_d;
      done_q   <= done_d;
    end
  end

  assign Output = out_q;
  assign busy   = (state_q == RUN);
  assign done   = done_q;

endmodule

// File: tb/tb_param_muldiv_alu.sv
module tb_param_muldiv_alu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dataA = '0;
  logic [W-1:0] dataB = '0;
  logic [5:0]   Signal = 6'd0;
  logic [W-1:0] Output;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  param_muldiv_alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .start  (start),
    .Output (Output),
    .busy   (busy),
    .done   (done)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0] exp_q[$];

  // Reference model state (value after the most recent edge).
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic         m_busy = 1'b0, m_done = 1'b0;
  int           m_cnt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] alu_ref(input logic [5:0] sig, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (sig)
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd42:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'd0:    return a << sh;
      6'd2:    return a >> sh;
      6'd16:   return m_hi;
      6'd18:   return m_lo;
      default: return '0;
    endcase
  endfunction

  // One clock cycle: drive inputs, push expected Output, advance model, check.
  task automatic step(input string tag, input bit rst, input logic [5:0] sig,
                      input logic [W-1:0] a, input logic [W-1:0] b, input bit st,
                      input bit lit, input logic [W-1:0] lit_val);
    logic [63:0] p;
    @(negedge clk);
    reset = rst; Signal = sig; dataA = a; dataB = b; start = st;
    if (rst)      exp_q.push_back('0);
    else if (lit) exp_q.push_back(lit_val);
    else          exp_q.push_back(alu_ref(sig, a, b));
    if (rst) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == W) begin
          m_hi = p_hi; m_lo = p_lo; m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (st && (sig == 6'd25 || sig == 6'd27)) begin
        m_busy = 1'b1; m_cnt = 0;
        if (sig == 6'd25) begin
          p = {32'd0, a} * {32'd0, b};
          p_hi = p[63:32]; p_lo = p[31:0];
        end else if (b == '0) begin
          p_hi = a; p_lo = '1;
        end else begin
          p_hi = a % b; p_lo = a / b;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    check({tag, ".out"}, Output, exp_q.pop_front());
    check({tag, ".busy"}, busy, m_busy);
    check({tag, ".done"}, done, m_done);
  endtask

  task automatic op(input string tag, input logic [5:0] sig, input logic [W-1:0] a,
                    input logic [W-1:0] b);
    step(tag, 1'b0, sig, a, b, 1'b0, 1'b0, '0);
  endtask

  task automatic op_lit(input string tag, input logic [5:0] sig, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] v);
    step(tag, 1'b0, sig, a, b, 1'b0, 1'b1, v);
  endtask

  task automatic go(input string tag, input logic [5:0] sig, input logic [W-1:0] a,
                    input logic [W-1:0] b);
    step(tag, 1'b0, sig, a, b, 1'b1, 1'b1, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op("run_add", 6'd32, $urandom, $urandom);
  endtask

  initial begin
    int acc_cyc;
    int lat;
    logic [5:0] codes[14];
    codes = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd0, 6'd2, 6'd16, 6'd18,
              6'd25, 6'd27, 6'd7, 6'd63, 6'd1};

    step("reset", 1'b1, 6'd32, 32'd1, 32'd2, 1'b1, 1'b0, '0);
    step("reset", 1'b1, 6'd25, 32'd3, 32'd4, 1'b1, 1'b0, '0);

    op_lit("add", 6'd32, 32'd7, 32'd5, 32'd12);
    op_lit("sub", 6'd34, 32'd5, 32'd7, 32'hFFFF_FFFE);
    op_lit("slt", 6'd42, 32'hFFFF_FFFF, 32'd1, 32'd1);
    op_lit("slt_neg", 6'd42, 32'd1, 32'hFFFF_FFFF, 32'd0);
    op_lit("sll", 6'd0, 32'd1, 32'd31, 32'h8000_0000);
    op_lit("srl", 6'd2, 32'h8000_0000, 32'd31, 32'd1);
    op_lit("srl_amt", 6'd2, 32'hF000_0000, 32'h0000_0124, 32'h0F00_0000);
    op_lit("and", 6'd36, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    op_lit("or", 6'd37, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
    op_lit("undef", 6'd7, 32'h1234, 32'h5678, 32'd0);

    go("divu", 6'd27, 32'd100, 32'd7);
    idle(W);
    op_lit("divu_lo", 6'd18, 32'd0, 32'd0, 32'd14);
    op_lit("divu_hi", 6'd16, 32'd0, 32'd0, 32'd2);

    go("multu", 6'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(3);
    go("restart_ignored", 6'd25, 32'd3, 32'd4);
    op_lit("stale_hi", 6'd16, 32'd0, 32'd0, 32'd2);
    op_lit("midrun_add", 6'd32, 32'd10, 32'd20, 32'd30);
    idle(W - 6);
    op_lit("multu_hi", 6'd16, 32'd0, 32'd0, 32'hFFFF_FFFE);
    op_lit("multu_lo", 6'd18, 32'd0, 32'd0, 32'd1);

    go("divu0", 6'd27, 32'd9, 32'd0);
    idle(W);
    op_lit("divu0_lo", 6'd18, 32'd0, 32'd0, 32'hFFFF_FFFF);
    op_lit("divu0_hi", 6'd16, 32'd0, 32'd0, 32'd9);

    go("abort", 6'd25, 32'd3, 32'd5);
    idle(9);
    step("abort_rst", 1'b1, 6'd25, 32'd6, 32'd6, 1'b1, 1'b0, '0);
    idle(W + 2);
    op_lit("abort_hi", 6'd16, 32'd0, 32'd0, 32'd0);
    op_lit("abort_lo", 6'd18, 32'd0, 32'd0, 32'd0);

    go("b2b_first", 6'd25, 32'd6, 32'd7);
    idle(W);
    go("b2b_second", 6'd27, 32'd50, 32'd8);
    acc_cyc = cyc;
    lat = -1;
    for (int i = 0; i < W + 4; i++) begin
      op("b2b_run", 6'd36, $urandom, $urandom);
      if (done && lat < 0) lat = cyc - acc_cyc;
    end
    check("b2b_latency", lat, W);
    op_lit("b2b_lo", 6'd18, 32'd0, 32'd0, 32'd6);
    op_lit("b2b_hi", 6'd16, 32'd0, 32'd0, 32'd2);

    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? '0 : $urandom;
      step("rand", ($urandom_range(0, 79) == 0), codes[$urandom_range(0, 13)], a, b,
           ($urandom_range(0, 3) == 0), 1'b0, '0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
